// File: rtl/shift_add_mult_ctrl_if.sv
// Request/result handshake bundle for the sequential shift-add multiplier.
// The slave modport is the multiplier side; the master modport is the requester/consumer side.
interface shift_add_mult_ctrl_if #(
    parameter int WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_product;
    logic                 busy;

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_product, busy
    );

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_product, busy
    );
endinterface

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned multiplier: one WIDTH-bit ripple adder, built from 4-bit RCA cells,
// is reused across WIDTH shift-add iterations behind valid/ready request and result ports.

module sam_rca4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[4];
    end
endmodule

module shift_add_mult_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    shift_add_mult_ctrl_if.slave  bus
);
    localparam int NCELL = WIDTH / 4;
    localparam int CW    = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    // Shared adder: ACC + (Q[0] ? M : 0), carry chained through the 4-bit cells.
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] sum;
    logic [NCELL:0]   carry;

    assign add_b    = q_q[0] ? m_q : '0;
    assign carry[0] = 1'b0;

    for (genvar g = 0; g < NCELL; g++) begin : g_cell
        sam_rca4 u_rca (
            .a    (acc_q[4*g +: 4]),
            .b    (add_b[4*g +: 4]),
            .cin  (carry[g]),
            .sum  (sum[4*g +: 4]),
            .cout (carry[g+1])
        );
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    m_d     = bus.in_a;
                    q_d     = bus.in_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Carry-out shifts into the ACC MSB, so no product bit is ever dropped.
                acc_d = {carry[NCELL], sum[WIDTH-1:1]};
                q_d   = {sum[0], q_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            m_q         <= '0;
            acc_q       <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            acc_q       <= acc_d;
            q_q         <= q_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.busy        = busy_q;
    assign bus.out_product = out_valid_q ? {acc_q, q_q} : '0;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench for shift_add_mult_ctrl at WIDTH=4 and WIDTH=8.
module tb_shift_add_mult_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    shift_add_mult_ctrl_if #(.WIDTH(4)) if4();
    shift_add_mult_ctrl_if #(.WIDTH(8)) if8();

    shift_add_mult_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    shift_add_mult_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        int          stall;
        logic [15:0] exp;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic do4(input logic [3:0] a, input logic [3:0] b, input int stall,
                       input logic [15:0] exp, input string nm);
        int n;
        @(negedge clk);
        check({nm, ".idle_ready"}, 64'(if4.in_ready), 64'd1);
        if4.in_valid  = 1'b1;
        if4.in_a      = a;
        if4.in_b      = b;
        if4.out_ready = 1'b0;
        @(negedge clk);
        if4.in_valid = 1'b0;
        if4.in_a     = ~a;
        if4.in_b     = ~b;
        check({nm, ".ready_drop"}, 64'(if4.in_ready), 64'd0);
        check({nm, ".busy"}, 64'(if4.busy), 64'd1);
        n = 0;
        while (!if4.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({nm, ".latency"}, 64'(n), 64'd4);
        check({nm, ".product"}, 64'(if4.out_product), 64'(exp));
        for (int i = 0; i < stall; i++) begin
            if4.in_valid = 1'($urandom_range(0, 1));
            if4.in_a     = 4'($urandom);
            @(negedge clk);
            check({nm, ".hold_valid"}, 64'(if4.out_valid), 64'd1);
            check({nm, ".hold_prod"}, 64'(if4.out_product), 64'(exp));
            check({nm, ".hold_ready"}, 64'(if4.in_ready), 64'd0);
        end
        if4.in_valid  = 1'b0;
        if4.out_ready = 1'b1;
        @(negedge clk);
        check({nm, ".back_idle"}, 64'({if4.out_valid, if4.in_ready, if4.busy}), 64'b010);
        check({nm, ".gated_prod"}, 64'(if4.out_product), 64'd0);
        if4.out_ready = 1'b0;
    endtask

    task automatic do8(input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp, input string nm);
        int n;
        @(negedge clk);
        if8.in_valid  = 1'b1;
        if8.in_a      = a;
        if8.in_b      = b;
        if8.out_ready = 1'b0;
        @(negedge clk);
        if8.in_valid = 1'b0;
        if8.in_a     = ~a;
        n = 0;
        while (!if8.out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check({nm, ".latency"}, 64'(n), 64'd8);
        check({nm, ".product"}, 64'(if8.out_product), 64'(exp));
        if8.out_ready = 1'b1;
        @(negedge clk);
        check({nm, ".back_idle"}, 64'({if8.out_valid, if8.in_ready}), 64'b01);
        if8.out_ready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl4[5];
        vec_t tbl8[3];
        logic [3:0] ra, rb;
        logic [7:0] sa, sb;
        int n, interval;
        logic prev, got1;

        tbl4[0] = '{a: 8'd9,  b: 8'd6,  stall: 0, exp: 16'd54};
        tbl4[1] = '{a: 8'd15, b: 8'd15, stall: 0, exp: 16'd225};
        tbl4[2] = '{a: 8'd0,  b: 8'd13, stall: 0, exp: 16'd0};
        tbl4[3] = '{a: 8'd11, b: 8'd0,  stall: 1, exp: 16'd0};
        tbl4[4] = '{a: 8'd7,  b: 8'd5,  stall: 6, exp: 16'd35};
        tbl8[0] = '{a: 8'd255, b: 8'd255, stall: 0, exp: 16'd65025};
        tbl8[1] = '{a: 8'd128, b: 8'd2,   stall: 0, exp: 16'd256};
        tbl8[2] = '{a: 8'd1,   b: 8'd200, stall: 0, exp: 16'd200};

        if4.in_valid = 1'b0; if4.in_a = '0; if4.in_b = '0; if4.out_ready = 1'b0;
        if8.in_valid = 1'b0; if8.in_a = '0; if8.in_b = '0; if8.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("reset4", 64'({if4.in_ready, if4.out_valid, if4.busy}), 64'b100);
        check("reset4.prod", 64'(if4.out_product), 64'd0);
        check("reset8", 64'({if8.in_ready, if8.out_valid, if8.busy}), 64'b100);
        rst = 1'b0;

        for (int i = 0; i < 5; i++)
            do4(tbl4[i].a[3:0], tbl4[i].b[3:0], tbl4[i].stall, tbl4[i].exp, $sformatf("tbl4[%0d]", i));

        for (int i = 0; i < 16; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            do4(ra, rb, int'($urandom_range(0, 2)), 16'(ra) * 16'(rb), $sformatf("rnd4[%0d]", i));
        end

        // Back-to-back: second pair is already waiting when the first completes.
        @(negedge clk);
        if4.out_ready = 1'b1;
        if4.in_valid  = 1'b1;
        if4.in_a      = 4'd5;
        if4.in_b      = 4'd4;
        @(negedge clk);
        if4.in_a = 4'd3;
        if4.in_b = 4'd12;
        prev = 1'b0; got1 = 1'b0; interval = 0;
        for (int k = 1; k <= 12 && interval == 0; k++) begin
            @(negedge clk);
            if (if4.out_valid && !got1) begin
                check("b2b.first_lat", 64'(k), 64'd4);
                check("b2b.first_prod", 64'(if4.out_product), 64'd20);
                got1 = 1'b1;
            end
            if (prev && !if4.in_ready) interval = k;
            prev = if4.in_ready;
        end
        if4.in_valid = 1'b0;
        check("b2b.interval", 64'(interval), 64'd6);
        n = 0;
        while (!if4.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b.second_lat", 64'(n), 64'd4);
        check("b2b.second_prod", 64'(if4.out_product), 64'd36);
        @(negedge clk);
        check("b2b.idle", 64'(if4.in_ready), 64'd1);
        if4.out_ready = 1'b0;

        // Reset two edges into RUN.
        @(negedge clk);
        if4.in_valid = 1'b1; if4.in_a = 4'd13; if4.in_b = 4'd10;
        @(negedge clk);
        if4.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("rst_run", 64'({if4.out_valid, if4.in_ready, if4.busy}), 64'b010);
        @(negedge clk);
        rst = 1'b0;
        do4(4'd2, 4'd3, 0, 16'd6, "post_rst");

        // Reset while the result waits in DONE: out_valid must drop without a clock edge.
        @(negedge clk);
        if4.in_valid = 1'b1; if4.in_a = 4'd6; if4.in_b = 4'd7; if4.out_ready = 1'b0;
        @(negedge clk);
        if4.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_done.pre", 64'({if4.out_valid, if4.out_product}), 64'({1'b1, 8'd42}));
        #2 rst = 1'b1;
        #1 check("rst_done", 64'({if4.out_valid, if4.in_ready, if4.busy}), 64'b010);
        check("rst_done.prod", 64'(if4.out_product), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 3; i++)
            do8(tbl8[i].a, tbl8[i].b, tbl8[i].exp, $sformatf("tbl8[%0d]", i));
        for (int i = 0; i < 8; i++) begin
            sa = 8'($urandom);
            sb = 8'($urandom);
            do8(sa, sb, 16'(sa) * 16'(sb), $sformatf("rnd8[%0d]", i));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
